// File: rtl/alu_pkg.sv
// alu_pkg: constants shared by the two-requester ALU arbiter.
//   - OP_* : 2-bit operation codes understood by alu2
//   - IDLE/EXEC/DONE : arbiter FSM state encoding
package alu_pkg;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XNOR = 2'b10;
  localparam logic [1:0] OP_NOTA = 2'b11;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] EXEC = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

endpackage

// File: rtl/alu2.sv
// alu2: 2-bit combinational logic unit, the resource shared by the arbiter.
// Ports:
//   a, b : operands
//   op   : operation code (OP_AND, OP_OR, OP_XNOR, OP_NOTA; b ignored for NOTA)
//   f    : result
module alu2
  import alu_pkg::*;
(
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic [1:0] op,
  output logic [1:0] f
);

  always_comb begin
    f = 2'b00;
    case (op)
      OP_AND:  f = a & b;
      OP_OR:   f = a | b;
      OP_XNOR: f = ~(a ^ b);
      OP_NOTA: f = ~a;
      default: f = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: grants one of two requesters access to a single alu2 and
// returns the result through a valid/ready result port.
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   reqN_valid/reqN_ready       : request handshake for requester N (N = 0, 1)
//   reqN_a, reqN_b, reqN_op     : operands and operation code of requester N
//   res_valid/res_ready         : result handshake
//   res_f, res_id               : result value and owning requester index
//   busy                        : FSM is not in IDLE
//   dbg_state                   : raw FSM state (IDLE/EXEC/DONE) for observation
// Parameter PRIO_FIXED: 0 = round robin, 1 = requester 0 always wins.
//
// Handshake rule: a transfer happens on a rising clk edge where valid and
// ready are both high; ready never depends on anything but state, the
// grant and valid, and a requester keeps valid and its operands stable
// until it sees its ready pulse.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int PRIO_FIXED = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [1:0] req0_a,
  input  logic [1:0] req0_b,
  input  logic [1:0] req0_op,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [1:0] req1_a,
  input  logic [1:0] req1_b,
  input  logic [1:0] req1_op,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [1:0] res_f,
  output logic       res_id,
  output logic       busy,
  output logic [1:0] dbg_state
);

  logic [1:0] state;
  logic       last_grant;
  logic       grant0;
  logic       grant1;
  logic       accept;
  logic [1:0] cap_a;
  logic [1:0] cap_b;
  logic [1:0] cap_op;
  logic       cap_id;
  logic [1:0] alu_f;

  // last_grant == 1 means requester 1 won last time, so requester 0 wins a tie.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (PRIO_FIXED != 0) begin
      grant0 = req0_valid;
      grant1 = req1_valid & ~req0_valid;
    end else if (req0_valid && req1_valid) begin
      grant0 = last_grant;
      grant1 = ~last_grant;
    end else begin
      grant0 = req0_valid;
      grant1 = req1_valid;
    end
  end

  // rst_n gates the readys so nothing looks accepted while reset is held.
  assign req0_ready = rst_n & (state == IDLE) & grant0;
  assign req1_ready = rst_n & (state == IDLE) & grant1;
  assign accept     = req0_ready | req1_ready;

  assign res_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  alu2 u_alu2 (
    .a  (cap_a),
    .b  (cap_b),
    .op (cap_op),
    .f  (alu_f)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cap_a      <= 2'b00;
      cap_b      <= 2'b00;
      cap_op     <= 2'b00;
      cap_id     <= 1'b0;
      res_f      <= 2'b00;
      res_id     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state      <= EXEC;
            last_grant <= req1_ready;
            cap_id     <= req1_ready;
            cap_a      <= req1_ready ? req1_a  : req0_a;
            cap_b      <= req1_ready ? req1_b  : req0_b;
            cap_op     <= req1_ready ? req1_op : req0_op;
          end
        end
        EXEC: begin
          state  <= DONE;
          res_f  <= alu_f;
          res_id <= cap_id;
        end
        DONE: begin
          if (res_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: self-checking bench for alu_arbiter. Two instances (round
// robin and fixed priority) share one set of stimulus signals; sel_fp picks
// which one sees the valids and whose outputs are observed.
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       sel_fp = 1'b0;
  logic       p0 = 1'b0, p1 = 1'b0;
  logic [1:0] a0 = 2'b00, b0 = 2'b00, op0 = 2'b00;
  logic [1:0] a1 = 2'b00, b1 = 2'b00, op1 = 2'b00;
  logic       res_ready = 1'b0;

  logic       rdy0_rr, rdy1_rr, rv_rr, id_rr, busy_rr;
  logic       rdy0_fp, rdy1_fp, rv_fp, id_fp, busy_fp;
  logic [1:0] f_rr, f_fp, st_rr, st_fp;

  logic       ready0, ready1, res_valid, res_id, busy;
  logic [1:0] res_f, dbg_state;

  alu_arbiter #(.PRIO_FIXED(0)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(p0 & ~sel_fp), .req0_ready(rdy0_rr), .req0_a(a0), .req0_b(b0), .req0_op(op0),
    .req1_valid(p1 & ~sel_fp), .req1_ready(rdy1_rr), .req1_a(a1), .req1_b(b1), .req1_op(op1),
    .res_valid(rv_rr), .res_ready(res_ready), .res_f(f_rr), .res_id(id_rr),
    .busy(busy_rr), .dbg_state(st_rr)
  );

  alu_arbiter #(.PRIO_FIXED(1)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(p0 & sel_fp), .req0_ready(rdy0_fp), .req0_a(a0), .req0_b(b0), .req0_op(op0),
    .req1_valid(p1 & sel_fp), .req1_ready(rdy1_fp), .req1_a(a1), .req1_b(b1), .req1_op(op1),
    .res_valid(rv_fp), .res_ready(res_ready), .res_f(f_fp), .res_id(id_fp),
    .busy(busy_fp), .dbg_state(st_fp)
  );

  assign ready0    = sel_fp ? rdy0_fp : rdy0_rr;
  assign ready1    = sel_fp ? rdy1_fp : rdy1_rr;
  assign res_valid = sel_fp ? rv_fp   : rv_rr;
  assign res_f     = sel_fp ? f_fp    : f_rr;
  assign res_id    = sel_fp ? id_fp   : id_rr;
  assign busy      = sel_fp ? busy_fp : busy_rr;
  assign dbg_state = sel_fp ? st_fp   : st_rr;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard / model state ----------------
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         m_phase = 0;   // 0 idle, 1 executing, 2 result offered
  int         m_last = 1;    // requester granted last
  logic [2:0] exp_q[$];      // {id, f} of accepted operations, oldest first
  int         acc_ids[$];
  int         hs_cyc[$];
  int         acc_cyc = 0;
  logic [1:0] last_f = 2'b00;
  logic       last_id = 1'b0;
  int         refill0 = 0, refill1 = 0;
  logic       rand_mode = 1'b0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Bit-serial arithmetic form of the op table.
  function automatic logic [1:0] alu_ref(input logic [1:0] a, input logic [1:0] b,
                                         input logic [1:0] op);
    logic [1:0] f;
    int x, y, r;
    f = 2'b00;
    for (int i = 0; i < 2; i++) begin
      x = int'(a[i]);
      y = int'(b[i]);
      case (op)
        2'd0:    r = x * y;
        2'd1:    r = x + y - x * y;
        2'd2:    r = (x == y) ? 1 : 0;
        default: r = 1 - x;
      endcase
      f[i] = r[0];
    end
    return f;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic new_req(input int id);
    if (id == 0) begin
      p0 = 1'b1; a0 = 2'($urandom_range(0, 3)); b0 = 2'($urandom_range(0, 3));
      op0 = 2'($urandom_range(0, 3));
    end else begin
      p1 = 1'b1; a1 = 2'($urandom_range(0, 3)); b1 = 2'($urandom_range(0, 3));
      op1 = 2'($urandom_range(0, 3));
    end
  endtask

  task automatic set_req(input int id, input logic [1:0] a, input logic [1:0] b,
                         input logic [1:0] op);
    if (id == 0) begin p0 = 1'b1; a0 = a; b0 = b; op0 = op; end
    else         begin p1 = 1'b1; a1 = a; b1 = b; op1 = op; end
  endtask

  // One clock cycle: compare outputs at negedge against the model, advance
  // the model across the posedge, then update requesters at posedge+1.
  task automatic step();
    int   g;
    logic hs;
    logic d0, d1;
    @(negedge clk);
    g = -1;
    if (m_phase == 0) begin
      if (sel_fp) begin
        if (p0) g = 0; else if (p1) g = 1;
      end else if (p0 && p1) g = 1 - m_last;
      else if (p0) g = 0;
      else if (p1) g = 1;
    end
    check("ready0", 8'(ready0), 8'(g == 0));
    check("ready1", 8'(ready1), 8'(g == 1));
    check("res_valid", 8'(res_valid), 8'(m_phase == 2));
    check("busy", 8'(busy), 8'(m_phase != 0));
    check("state", 8'(dbg_state), 8'(m_phase));
    if (m_phase == 2 && exp_q.size() > 0) begin
      check("res_f", 8'(res_f), 8'(exp_q[0][1:0]));
      check("res_id", 8'(res_id), 8'(exp_q[0][2]));
    end
    hs = (m_phase == 2) && res_ready;
    d0 = ready0;
    d1 = ready1;
    if (g >= 0) begin
      if (g == 0) exp_q.push_back({1'b0, alu_ref(a0, b0, op0)});
      else        exp_q.push_back({1'b1, alu_ref(a1, b1, op1)});
      m_last = g; m_phase = 1; acc_ids.push_back(g); acc_cyc = cyc + 1;
    end else if (m_phase == 1) begin
      m_phase = 2;
    end else if (hs) begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      m_phase = 0; last_f = res_f; last_id = res_id; hs_cyc.push_back(cyc + 1);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (d0) begin p0 = 1'b0; if (refill0 > 0) begin refill0--; new_req(0); end end
    if (d1) begin p1 = 1'b0; if (refill1 > 0) begin refill1--; new_req(1); end end
    if (rand_mode) begin
      if (!p0 && $urandom_range(0, 2) == 0) new_req(0);
      if (!p1 && $urandom_range(0, 2) == 0) new_req(1);
      res_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic run_until_idle(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (m_phase == 0 && !p0 && !p1) return;
      step();
    end
    check("drain_timeout", 8'd1, 8'd0);
  endtask

  // Called at posedge+1; asserts reset asynchronously and checks reset values.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_res_valid", 8'(res_valid), 8'd0);
    check("rst_busy", 8'(busy), 8'd0);
    check("rst_res_f", 8'(res_f), 8'd0);
    check("rst_res_id", 8'(res_id), 8'd0);
    check("rst_ready0", 8'(ready0), 8'd0);
    check("rst_ready1", 8'(ready1), 8'd0);
    m_phase = 0; m_last = 1; exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    cyc += 2;
    check("rst_hold_ready0", 8'(ready0), 8'd0);
    check("rst_hold_ready1", 8'(ready1), 8'd0);
    rst_n = 1'b1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [1:0] op_exp[4];
    op_exp[0] = 2'b01; op_exp[1] = 2'b11; op_exp[2] = 2'b01; op_exp[3] = 2'b10;

    @(posedge clk);
    #1;
    // Single request, pending already while reset is held.
    set_req(0, 2'b10, 2'b11, 2'b00);
    res_ready = 1'b1;
    do_reset();
    run_until_idle(20);
    check("single_f", 8'(last_f), 8'h02);
    check("single_id", 8'(last_id), 8'd0);
    if (hs_cyc.size() > 0) check("single_latency", 8'(hs_cyc[$] - acc_cyc), 8'd2);
    else check("single_no_result", 8'd1, 8'd0);

    // Every op on a=01, b=11.
    for (int k = 0; k < 4; k++) begin
      set_req(0, 2'b01, 2'b11, 2'(k));
      run_until_idle(20);
      check($sformatf("op%0d_f", k), 8'(last_f), 8'(op_exp[k]));
    end

    // Round-robin tie with both requesters always pending.
    do_reset();
    acc_ids.delete(); hs_cyc.delete();
    new_req(0); new_req(1);
    refill0 = 3; refill1 = 3;
    for (int i = 0; i < 40 && hs_cyc.size() < 4; i++) step();
    refill0 = 0; refill1 = 0;
    if (acc_ids.size() >= 4 && hs_cyc.size() >= 4) begin
      for (int i = 0; i < 4; i++) check($sformatf("rr_grant%0d", i), 8'(acc_ids[i]), 8'(i % 2));
      for (int i = 1; i < 4; i++) check($sformatf("rr_spacing%0d", i), 8'(hs_cyc[i] - hs_cyc[i-1]), 8'd3);
    end else check("rr_too_few_grants", 8'(acc_ids.size()), 8'd4);
    run_until_idle(40);

    // Back-pressure: hold res_ready low for 5 cycles in DONE, req0 waiting.
    res_ready = 1'b0;
    set_req(1, 2'b11, 2'b01, 2'b10);
    for (int i = 0; i < 10 && m_phase != 2; i++) step();
    set_req(0, 2'b01, 2'b01, 2'b01);
    repeat (5) step();
    res_ready = 1'b1;
    step();
    check("bp_idle_after", 8'(dbg_state), 8'd0);
    check("bp_f", 8'(last_f), 8'h01);
    check("bp_id", 8'(last_id), 8'd1);
    run_until_idle(20);

    // Reset during EXEC discards the in-flight operation.
    set_req(0, 2'b11, 2'b11, 2'b00);
    step();
    check("mid_busy_before", 8'(busy), 8'd1);
    do_reset();
    run_until_idle(10);
    set_req(1, 2'b01, 2'b11, 2'b01);
    run_until_idle(20);
    check("post_rst_f", 8'(last_f), 8'h03);
    check("post_rst_id", 8'(last_id), 8'd1);

    // Random traffic with random back-pressure, round robin.
    rand_mode = 1'b1;
    repeat (400) step();
    rand_mode = 1'b0;
    res_ready = 1'b1;
    run_until_idle(40);

    // Fixed priority: req0 wins three times, then req1 once req0 drops.
    sel_fp = 1'b1;
    do_reset();
    acc_ids.delete();
    new_req(0); new_req(1);
    refill0 = 2;
    run_until_idle(60);
    if (acc_ids.size() == 4) begin
      for (int i = 0; i < 4; i++) check($sformatf("fp_grant%0d", i), 8'(acc_ids[i]), 8'(i == 3));
    end else check("fp_grant_count", 8'(acc_ids.size()), 8'd4);

    rand_mode = 1'b1;
    repeat (200) step();
    rand_mode = 1'b0;
    res_ready = 1'b1;
    run_until_idle(40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
